// File: rtl/naneye_cfg_tx.sv
// rtl/naneye_cfg_tx.sv - Manchester encoder/serializer for NanEye sensor config words
//
// Holds one host config word, waits for a config window from the receive
// decoder, then drives a framed Manchester word onto the shared sensor line.
//
// Ports:
//   SCLOCK       sample clock, all logic on the rising edge
//   RESET        asynchronous active-high reset
//   ENABLE       module activation; low aborts and holds the block idle
//   CONFIG_EN    config window from the decoder; a rising edge starts the frame
//   CFG_DATA     config word
//   CFG_VALID    CFG_DATA valid
//   CFG_READY    block can accept a word
//   TX_OUT       Manchester-coded serial output
//   TX_OE        line driver enable
//   CONFIG_DONE  one-cycle pulse at the end of a completed frame
//   BUSY         a word is held or a frame is in flight
module naneye_cfg_tx #(
    parameter int   HALF_BIT   = 10,
    parameter int   CFG_BITS   = 16,
    parameter int   START_BITS = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                SCLOCK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                CONFIG_EN,
    input  logic [CFG_BITS-1:0] CFG_DATA,
    input  logic                CFG_VALID,
    output logic                CFG_READY,
    output logic                TX_OUT,
    output logic                TX_OE,
    output logic                CONFIG_DONE,
    output logic                BUSY
);

    localparam int MAX_BITS = (START_BITS > CFG_BITS) ? START_BITS : CFG_BITS;
    localparam int BCW      = $clog2(MAX_BITS + 1);
    localparam int HCW      = $clog2(HALF_BIT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WIN,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    logic                cfg_en_q;
    logic                cfg_en_rise;
    logic [HCW-1:0]      half_cnt;
    logic                phase;
    logic [BCW-1:0]      bit_cnt;
    logic [CFG_BITS-1:0] word_q;
    logic [CFG_BITS-1:0] word_shifted;
    logic                half_end;

    assign cfg_en_rise  = CONFIG_EN & ~cfg_en_q;
    assign half_end     = (half_cnt == HCW'(HALF_BIT - 1));
    // The held word doubles as the data shift register, MSB on the line first.
    assign word_shifted = word_q << 1;

    always_ff @(posedge SCLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cfg_en_q    <= 1'b0;
            half_cnt    <= '0;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            word_q      <= '0;
            CFG_READY   <= 1'b0;
            TX_OUT      <= IDLE_LEVEL;
            TX_OE       <= 1'b0;
            CONFIG_DONE <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            cfg_en_q    <= CONFIG_EN;
            CONFIG_DONE <= 1'b0;
            if (!ENABLE) begin
                state     <= IDLE;
                half_cnt  <= '0;
                phase     <= 1'b0;
                bit_cnt   <= '0;
                word_q    <= '0;
                CFG_READY <= 1'b0;
                TX_OUT    <= IDLE_LEVEL;
                TX_OE     <= 1'b0;
                BUSY      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A CONFIG_EN rise in this same cycle is deliberately
                        // not used; only a rise seen in WAIT_WIN starts a frame.
                        if (CFG_VALID && CFG_READY) begin
                            word_q    <= CFG_DATA;
                            state     <= WAIT_WIN;
                            CFG_READY <= 1'b0;
                            BUSY      <= 1'b1;
                        end else begin
                            CFG_READY <= 1'b1;
                            BUSY      <= 1'b0;
                        end
                    end
                    WAIT_WIN: begin
                        if (cfg_en_rise) begin
                            state    <= START;
                            half_cnt <= '0;
                            phase    <= 1'b0;
                            bit_cnt  <= '0;
                            TX_OE    <= 1'b1;
                            TX_OUT   <= 1'b1;
                        end
                    end
                    default: begin
                        if (!half_end) begin
                            half_cnt <= half_cnt + 1'b1;
                        end else begin
                            half_cnt <= '0;
                            phase    <= ~phase;
                            if (!phase) begin
                                // Manchester always inverts at mid-bit.
                                TX_OUT <= ~TX_OUT;
                            end else if (state == START) begin
                                if (bit_cnt == BCW'(START_BITS - 1)) begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                    TX_OUT  <= word_q[CFG_BITS-1];
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    TX_OUT  <= 1'b1;
                                end
                            end else if (state == DATA) begin
                                word_q <= word_shifted;
                                if (bit_cnt == BCW'(CFG_BITS - 1)) begin
                                    state   <= STOP;
                                    bit_cnt <= '0;
                                    TX_OUT  <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    TX_OUT  <= word_shifted[CFG_BITS-1];
                                end
                            end else begin
                                state       <= IDLE;
                                word_q      <= '0;
                                TX_OE       <= 1'b0;
                                TX_OUT      <= IDLE_LEVEL;
                                CONFIG_DONE <= 1'b1;
                                BUSY        <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
